// File: rtl/lcd_bcd_formatter.sv
// Sequential binary-to-ASCII decimal converter (shift-add-3) feeding the LCD text path.
// Define LEADING_ZERO_BLANK_EN to show leading zero digits as spaces in ascii_o.
module lcd_bcd_formatter #(
    parameter int         IN_BITS      = 8,
    parameter int         DIGITS       = 3,
    parameter logic [7:0] ASCII_OFFSET = 8'h30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [IN_BITS-1:0]    bin_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [DIGITS*4-1:0]   bcd_o,
    output logic [DIGITS*8-1:0]   ascii_o
);

    localparam int CNT_W = $clog2(IN_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IN_BITS-1:0]    shift_q, shift_d;
    logic [DIGITS*4-1:0]   scratch_q, scratch_d, scratch_adj;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic [DIGITS*4-1:0]   bcd_q, bcd_d;
    logic [DIGITS*8-1:0]   ascii_q, ascii_d;
`ifdef LEADING_ZERO_BLANK_EN
    logic                  lead;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            bcd_q     <= '0;
            ascii_q   <= {DIGITS{ASCII_OFFSET}};
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            bcd_q     <= bcd_d;
            ascii_q   <= ascii_d;
        end
    end

    // Next state plus the conversion datapath that advances with it.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        scratch_adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    shift_d   = bin_i;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = S_CONVERT;
                end
            end
            S_CONVERT: begin
                // Bit shifted out of the top digit is always zero given the DIGITS sizing.
                {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o  = (state_q == S_CONVERT);
        valid_d = 1'b0;
        bcd_d   = bcd_q;
        ascii_d = ascii_q;
`ifdef LEADING_ZERO_BLANK_EN
        lead    = 1'b1;
`endif
        if (state_q == S_DONE) begin
            valid_d = 1'b1;
            bcd_d   = scratch_q;
            for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
                if (lead && (i != 0) && (scratch_q[4*i +: 4] == 4'd0)) begin
                    ascii_d[8*i +: 8] = 8'h20;
                end else begin
                    lead              = 1'b0;
                    ascii_d[8*i +: 8] = ASCII_OFFSET + {4'b0000, scratch_q[4*i +: 4]};
                end
`else
                ascii_d[8*i +: 8] = ASCII_OFFSET + {4'b0000, scratch_q[4*i +: 4]};
`endif
            end
        end
    end

    assign valid_o = valid_q;
    assign bcd_o   = bcd_q;
    assign ascii_o = ascii_q;

endmodule

// File: tb/tb_lcd_bcd_formatter.sv
// Bench for lcd_bcd_formatter: directed scenarios plus random traffic against a decimal reference model.
module tb_lcd_bcd_formatter;

    localparam int IN_BITS = 8;
    localparam int DIGITS  = 3;
    localparam logic [23:0] RESET_ASCII = 24'h303030;

    logic                clk;
    logic                reset;
    logic                start_i;
    logic [IN_BITS-1:0]  bin_i;
    logic                busy_o;
    logic                valid_o;
    logic [DIGITS*4-1:0] bcd_o;
    logic [DIGITS*8-1:0] ascii_o;

    int checks   = 0;
    int failures = 0;

    lcd_bcd_formatter dut (
        .clk     (clk),
        .reset   (reset),
        .start_i (start_i),
        .bin_i   (bin_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .bcd_o   (bcd_o),
        .ascii_o (ascii_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference: decimal digits by plain division.
    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [23:0] ref_ascii(input int v);
        logic [23:0] r;
        logic [11:0] d;
        bit lead;
        d = ref_bcd(v);
        lead = 1'b1;
        r = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (lead && k != 0 && d[4*k +: 4] == 4'd0) begin
                r[8*k +: 8] = 8'h20;
            end else begin
                lead = 1'b0;
                r[8*k +: 8] = 8'h30 + {4'b0000, d[4*k +: 4]};
            end
`else
            r[8*k +: 8] = 8'h30 + {4'b0000, d[4*k +: 4]};
`endif
        end
        return r;
    endfunction

    // Timing model: cycles left until back in idle; 0 means a start would be accepted.
    int          remain    = 0;
    int          cap       = 0;
    bit          exp_valid = 1'b0;
    logic [11:0] exp_bcd   = '0;
    logic [23:0] exp_ascii = RESET_ASCII;

    always @(posedge clk) begin
        if (reset) begin
            remain    = 0;
            exp_valid = 1'b0;
            exp_bcd   = '0;
            exp_ascii = RESET_ASCII;
        end else begin
            exp_valid = 1'b0;
            if (remain == 0) begin
                if (start_i) begin
                    cap    = int'(bin_i);
                    remain = IN_BITS + 1;
                end
            end else begin
                remain--;
                if (remain == 0) begin
                    exp_valid = 1'b1;
                    exp_bcd   = ref_bcd(cap);
                    exp_ascii = ref_ascii(cap);
                end
            end
        end
    end

    // scoreboard: compare every cycle on the falling edge
    int n_valid = 0;
    int n_busy  = 0;

    always @(negedge clk) begin
        check("valid", {31'b0, valid_o}, {31'b0, exp_valid});
        check("busy",  {31'b0, busy_o},  {31'b0, (remain >= 2)});
        check("bcd",   {20'b0, bcd_o},   {20'b0, exp_bcd});
        check("ascii", {8'b0, ascii_o},  {8'b0, exp_ascii});
        if (valid_o) n_valid++;
        if (busy_o)  n_busy++;
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic convert(input logic [IN_BITS-1:0] v);
        bin_i   = v;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        tick(IN_BITS + 2);
    endtask

    int v0, b0;
    int          blank_vals [4];
    logic [23:0] blank_exp  [4];
    logic [7:0]  b2b        [3];

    initial begin
        reset   = 1'b1;
        start_i = 1'b0;
        bin_i   = '0;
        tick(3);
        reset = 1'b0;

        // idle after reset
        tick(20);
        check("idle_ascii", {8'b0, ascii_o}, {8'b0, RESET_ASCII});
        check("idle_valid_cnt", n_valid, 0);

        // full-scale value
        v0 = n_valid;
        b0 = n_busy;
        convert(8'd255);
        check("c255_busy_cycles", n_busy - b0, 8);
        check("c255_valid_cnt", n_valid - v0, 1);
        check("c255_bcd", {20'b0, bcd_o}, 32'h255);
        check("c255_ascii", {8'b0, ascii_o}, 32'h323535);

        // back-to-back conversions
        b2b[0] = 8'd0;
        b2b[1] = 8'd100;
        b2b[2] = 8'd9;
        v0 = n_valid;
        for (int i = 0; i < 3; i++) begin
            bin_i   = b2b[i];
            start_i = 1'b1;
            tick(1);
            start_i = 1'b0;
            tick(IN_BITS + 1);
        end
        tick(2);
        check("b2b_valid_cnt", n_valid - v0, 3);

        // start held high while bin_i toggles
        v0 = n_valid;
        start_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bin_i = (i % 2 == 1) ? 8'd200 : 8'd42;
            tick(1);
        end
        start_i = 1'b0;
        tick(12);
        check("held_valid_cnt", n_valid - v0, 2);

        // reset during conversion
        v0 = n_valid;
        bin_i   = 8'd123;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        tick(3);
        reset = 1'b1;
        start_i = 1'b1;
        tick(1);
        reset = 1'b0;
        start_i = 1'b0;
        tick(12);
        check("midreset_valid_cnt", n_valid - v0, 0);
        check("midreset_ascii", {8'b0, ascii_o}, {8'b0, RESET_ASCII});
        convert(8'd123);
        check("c123_ascii", {8'b0, ascii_o}, 32'h313233);

`ifdef LEADING_ZERO_BLANK_EN
        blank_vals[0] = 7;   blank_exp[0] = 24'h202037;
        blank_vals[1] = 40;  blank_exp[1] = 24'h203430;
        blank_vals[2] = 0;   blank_exp[2] = 24'h202030;
        blank_vals[3] = 205; blank_exp[3] = 24'h323035;
        for (int i = 0; i < 4; i++) begin
            convert(8'(blank_vals[i]));
            check("blank_ascii", {8'b0, ascii_o}, {8'b0, blank_exp[i]});
        end
`else
        blank_vals[0] = 7;   blank_exp[0] = 24'h303037;
        blank_vals[1] = 40;  blank_exp[1] = 24'h303430;
        blank_vals[2] = 0;   blank_exp[2] = 24'h303030;
        blank_vals[3] = 205; blank_exp[3] = 24'h323035;
        for (int i = 0; i < 4; i++) begin
            convert(8'(blank_vals[i]));
            check("zero_ascii", {8'b0, ascii_o}, {8'b0, blank_exp[i]});
        end
`endif

        // random traffic, including stray starts and rare resets
        for (int i = 0; i < 600; i++) begin
            start_i = ($urandom_range(0, 2) == 0);
            bin_i   = 8'($urandom_range(0, 255));
            reset   = ($urandom_range(0, 149) == 0);
            tick(1);
        end
        start_i = 1'b0;
        reset   = 1'b0;
        tick(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
